// File: rtl/alu_mdu_if.sv
// Request/response bundle for alu_mdu: operand request handshake, flush and registered result.
// The master drives requests and result acceptance; the slave (the unit) drives readiness and results.
interface alu_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             W_flush;
  logic             W_in_valid;
  logic             R_in_ready;
  logic [3:0]       W_op_sel;
  logic [WIDTH-1:0] W_a;
  logic [WIDTH-1:0] W_b;
  logic             R_out_valid;
  logic             W_out_ready;
  logic [WIDTH-1:0] R_res_lo;
  logic [WIDTH-1:0] R_res_hi;
  logic             R_overflow;
  logic             R_div_zero;

  modport master (
    output W_flush, W_in_valid, W_op_sel, W_a, W_b, W_out_ready,
    input  R_in_ready, R_out_valid, R_res_lo, R_res_hi, R_overflow, R_div_zero
  );

  modport slave (
    input  W_flush, W_in_valid, W_op_sel, W_a, W_b, W_out_ready,
    output R_in_ready, R_out_valid, R_res_lo, R_res_hi, R_overflow, R_div_zero
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative multiply/divide: single-cycle logic/add/shift/compare ops,
// radix-2 shift-add multiply and restoring divide at one bit per cycle, one op in flight.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic      clk,
  input  logic      rst,
  alu_mdu_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpSlt  = 4'd4;
  localparam logic [3:0] OpSltu = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpNor  = 4'd7;
  localparam logic [3:0] OpSll  = 4'd8;
  localparam logic [3:0] OpSrl  = 4'd9;
  localparam logic [3:0] OpSra  = 4'd10;
  localparam logic [3:0] OpMult = 4'd11;
  localparam logic [3:0] OpMulu = 4'd12;
  localparam logic [3:0] OpDiv  = 4'd13;
  localparam logic [3:0] OpDivu = 4'd14;

  state_e           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd;
  logic             r_neg_q, r_neg_r;
  logic             r_out_valid, r_ovf, r_dz;
  logic [WIDTH-1:0] r_res_lo, r_res_hi;

  logic             w_in_ready, w_accept;
  logic [WIDTH-1:0] w_sum, w_diff, w_simple;
  logic             w_ovf;
  logic [SHW-1:0]   w_amt;
  logic             w_sgn, w_a_neg, w_b_neg, w_is_mul, w_is_div;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;

  assign w_in_ready = (r_state == StIdle) | ((r_state == StDone) & bus.W_out_ready);
  assign w_accept   = bus.W_in_valid & w_in_ready;

  assign w_sum  = bus.W_a + bus.W_b;
  assign w_diff = bus.W_a - bus.W_b;
  assign w_amt  = bus.W_b[SHW-1:0];

  always_comb begin
    w_simple = '0;
    w_ovf    = 1'b0;
    case (bus.W_op_sel)
      OpAdd: begin
        w_simple = w_sum;
        w_ovf    = (bus.W_a[WIDTH-1] == bus.W_b[WIDTH-1]) & (w_sum[WIDTH-1] != bus.W_a[WIDTH-1]);
      end
      OpSub: begin
        w_simple = w_diff;
        w_ovf    = (bus.W_a[WIDTH-1] != bus.W_b[WIDTH-1]) & (w_diff[WIDTH-1] != bus.W_a[WIDTH-1]);
      end
      OpAnd:  w_simple = bus.W_a & bus.W_b;
      OpOr:   w_simple = bus.W_a | bus.W_b;
      OpSlt:  w_simple = {{(WIDTH-1){1'b0}}, ($signed(bus.W_a) < $signed(bus.W_b))};
      OpSltu: w_simple = {{(WIDTH-1){1'b0}}, (bus.W_a < bus.W_b)};
      OpXor:  w_simple = bus.W_a ^ bus.W_b;
      OpNor:  w_simple = ~(bus.W_a | bus.W_b);
      OpSll:  w_simple = bus.W_a << w_amt;
      OpSrl:  w_simple = bus.W_a >> w_amt;
      OpSra:  w_simple = WIDTH'($signed(bus.W_a) >>> w_amt);
      default: ;
    endcase
  end

  // Iterative ops run on magnitudes; signs are reapplied on the final step.
  assign w_is_mul = (bus.W_op_sel == OpMult) | (bus.W_op_sel == OpMulu);
  assign w_is_div = (bus.W_op_sel == OpDiv)  | (bus.W_op_sel == OpDivu);
  assign w_sgn    = (bus.W_op_sel == OpMult) | (bus.W_op_sel == OpDiv);
  assign w_a_neg  = w_sgn & bus.W_a[WIDTH-1];
  assign w_b_neg  = w_sgn & bus.W_b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -bus.W_a : bus.W_a;
  assign w_abs_b  = w_b_neg ? -bus.W_b : bus.W_b;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
  logic [2*WIDTH-1:0] w_mul_prod, w_mul_fin;

  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi   = w_mul_sum[WIDTH:1];
  assign w_mul_lo   = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_mul_prod = {w_mul_hi, w_mul_lo};
  assign w_mul_fin  = r_neg_q ? -w_mul_prod : w_mul_prod;

  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem, w_div_q, w_div_fq, w_div_fr;

  // Remainder stays below the divisor, so the low WIDTH bits of the subtraction suffice.
  assign w_div_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_opnd};
  assign w_div_rem = w_div_ge ? (w_div_sh[WIDTH-1:0] - r_opnd) : w_div_sh[WIDTH-1:0];
  assign w_div_q   = {r_acc_lo[WIDTH-2:0], w_div_ge};
  assign w_div_fq  = r_neg_q ? -w_div_q : w_div_q;
  assign w_div_fr  = r_neg_r ? -w_div_rem : w_div_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_opnd      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_res_lo    <= '0;
      r_res_hi    <= '0;
    end else if (bus.W_flush) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        StMul: begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          r_cnt    <= r_cnt - SHW'(1);
          if (r_cnt == '0) begin
            r_state               <= StDone;
            r_out_valid           <= 1'b1;
            {r_res_hi, r_res_lo}  <= w_mul_fin;
          end
        end
        StDiv: begin
          r_acc_hi <= w_div_rem;
          r_acc_lo <= w_div_q;
          r_cnt    <= r_cnt - SHW'(1);
          if (r_cnt == '0) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_res_lo    <= w_div_fq;
            r_res_hi    <= w_div_fr;
          end
        end
        StIdle, StDone: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
            r_cnt       <= SHW'(WIDTH - 1);
            r_acc_hi    <= '0;
            r_acc_lo    <= w_abs_a;
            r_opnd      <= w_abs_b;
            r_neg_q     <= w_a_neg ^ w_b_neg;
            r_neg_r     <= w_a_neg;
            if (w_is_mul) begin
              r_state <= StMul;
            end else if (w_is_div && (bus.W_b != '0)) begin
              r_state <= StDiv;
            end else begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
              if (w_is_div) begin
                r_res_lo <= '1;
                r_res_hi <= bus.W_a;
                r_dz     <= 1'b1;
              end else begin
                r_res_lo <= w_simple;
                r_res_hi <= '0;
                r_ovf    <= w_ovf;
              end
            end
          end else if ((r_state == StDone) && bus.W_out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.R_in_ready  = w_in_ready;
  assign bus.R_out_valid = r_out_valid;
  assign bus.R_res_lo    = r_res_lo;
  assign bus.R_res_hi    = r_res_hi;
  assign bus.R_overflow  = r_ovf;
  assign bus.R_div_zero  = r_dz;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vector table, random ops against an arithmetic
// reference model, and hand-written handshake, flush and reset sequences.
module tb_alu_mdu;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  alu_mdu_if #(.WIDTH(32)) bus ();

  alu_mdu #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ov;
    logic        dz;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd11 || op == 4'd12) return 33;
    if ((op == 4'd13 || op == 4'd14) && b != 32'd0) return 33;
    return 1;
  endfunction

  // Reference: plain 64-bit arithmetic on the operands' numeric values.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic ov, output logic dz);
    longint      sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = '0; hi = '0; ov = 1'b0; dz = 1'b0;
    case (op)
      4'd0: begin r = sa + sb; lo = 32'(r); ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd1: begin r = sa - sb; lo = 32'(r); ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: lo = (a < b) ? 32'd1 : 32'd0;
      4'd6: lo = a ^ b;
      4'd7: lo = ~(a | b);
      4'd8: lo = a << b[4:0];
      4'd9: lo = a >> b[4:0];
      4'd10: lo = 32'(sa >>> b[4:0]);
      4'd11: begin r = sa * sb; p = 64'(r); hi = p[63:32]; lo = p[31:0]; end
      4'd12: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      4'd13, 4'd14: begin
        if (b == 32'd0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (op == 4'd13) begin
          lo = 32'(sa / sb); hi = 32'(sa % sb);
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one op from idle, scramble the inputs after accept, wait (bounded) for the result, consume it.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi,
                       output logic ov, output logic dz, output int lat);
    @(negedge clk);
    bus.W_op_sel    = op;
    bus.W_a         = a;
    bus.W_b         = b;
    bus.W_in_valid  = 1'b1;
    bus.W_out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.W_in_valid = 1'b0;
    bus.W_a        = ~a;
    bus.W_b        = a ^ b;
    bus.W_op_sel   = op + 4'd3;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.R_out_valid && lat < 100);
    lo = bus.R_res_lo;
    hi = bus.R_res_hi;
    ov = bus.R_overflow;
    dz = bus.R_div_zero;
    bus.W_out_ready = 1'b1;
    @(negedge clk);
    bus.W_out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] lo, hi, elo, ehi;
    logic        ov, dz, eov, edz, seen;
    int          lat;
    logic [3:0]  op;
    logic [31:0] a, b;

    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.W_flush = 1'b0;
    bus.W_in_valid = 1'b0;
    bus.W_op_sel = '0;
    bus.W_a = '0;
    bus.W_b = '0;
    bus.W_out_ready = 1'b0;

    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 32'h0,        1'b1, 1'b0};
    vecs[1]  = '{4'd1,  32'h80000000, 32'd1,        32'h7FFFFFFF, 32'h0,        1'b1, 1'b0};
    vecs[2]  = '{4'd2,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{4'd3,  32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{4'd4,  32'hFFFFFFFF, 32'd1,        32'd1,        32'h0,        1'b0, 1'b0};
    vecs[5]  = '{4'd5,  32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        1'b0, 1'b0};
    vecs[6]  = '{4'd6,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{4'd7,  32'hFF00FF00, 32'h0F0F0F0F, 32'h00F000F0, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{4'd8,  32'd1,        32'd31,       32'h80000000, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{4'd9,  32'h80000000, 32'h24,       32'h08000000, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{4'd10, 32'h80000000, 32'h24,       32'hF8000000, 32'h0,        1'b0, 1'b0};
    vecs[11] = '{4'd11, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[12] = '{4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[13] = '{4'd13, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[14] = '{4'd14, 32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        1'b0, 1'b1};
    vecs[15] = '{4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b0};
    vecs[16] = '{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[17] = '{4'd14, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {bus.R_in_ready, bus.R_out_valid, bus.R_res_lo, bus.R_res_hi,
                          bus.R_overflow, bus.R_div_zero}, {1'b1, 1'b0, 64'd0, 2'b00});

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lo, hi, ov, dz, lat);
      check($sformatf("vec%0d_op%0d_result", i, vecs[i].op), {lo, hi, ov, dz},
            {vecs[i].lo, vecs[i].hi, vecs[i].ov, vecs[i].dz});
      check($sformatf("vec%0d_op%0d_latency", i, vecs[i].op), lat, exp_lat(vecs[i].op, vecs[i].b));
    end

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
      model(op, a, b, elo, ehi, eov, edz);
      do_op(op, a, b, lo, hi, ov, dz, lat);
      check($sformatf("rand%0d_op%0d_a%0h_b%0h", i, op, a, b), {lo, hi, ov, dz}, {elo, ehi, eov, edz});
      check($sformatf("rand%0d_latency", i), lat, exp_lat(op, b));
    end

    // Backpressure: result held while the consumer stalls, then a new op is taken on release.
    @(negedge clk);
    bus.W_op_sel = 4'd0; bus.W_a = 32'd10; bus.W_b = 32'd20;
    bus.W_in_valid = 1'b1; bus.W_out_ready = 1'b0;
    @(posedge clk);
    #1 bus.W_in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", i), {bus.R_out_valid, bus.R_in_ready, bus.R_res_lo},
            {1'b1, 1'b0, 32'd30});
    end
    @(negedge clk);
    bus.W_out_ready = 1'b1; bus.W_in_valid = 1'b1;
    bus.W_op_sel = 4'd1; bus.W_a = 32'd5; bus.W_b = 32'd3;
    #1 check("stall_release_ready", bus.R_in_ready, 1'b1);
    @(posedge clk);
    #1 begin bus.W_in_valid = 1'b0; bus.W_out_ready = 1'b0; end
    @(negedge clk);
    check("stall_new_op", {bus.R_out_valid, bus.R_res_lo}, {1'b1, 32'd2});
    bus.W_out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back simple ops at one per cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("b2b%0d", i - 1), {bus.R_out_valid, bus.R_res_lo}, {1'b1, 32'(i + 99)});
      bus.W_op_sel = 4'd0; bus.W_a = 32'(i); bus.W_b = 32'd100;
      bus.W_in_valid = 1'b1; bus.W_out_ready = 1'b1;
    end
    @(negedge clk);
    check("b2b4", {bus.R_out_valid, bus.R_res_lo}, {1'b1, 32'd104});
    bus.W_in_valid = 1'b0;
    @(negedge clk);
    bus.W_out_ready = 1'b0;
    check("b2b_drained", {bus.R_out_valid, bus.R_in_ready}, {1'b0, 1'b1});

    // Flush at cycle 10 of a MULT: the result must never appear.
    @(negedge clk);
    bus.W_op_sel = 4'd11; bus.W_a = 32'd3; bus.W_b = 32'd5; bus.W_in_valid = 1'b1;
    @(posedge clk);
    #1 bus.W_in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.W_flush = 1'b1;
    @(negedge clk);
    bus.W_flush = 1'b0;
    check("flush_mult_state", {bus.R_out_valid, bus.R_in_ready}, {1'b0, 1'b1});
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.R_out_valid) seen = 1'b1;
    end
    check("flush_mult_no_result", seen, 1'b0);

    // Flush in the same cycle as an accept drops the op.
    @(negedge clk);
    bus.W_op_sel = 4'd0; bus.W_a = 32'd1; bus.W_b = 32'd1;
    bus.W_in_valid = 1'b1; bus.W_flush = 1'b1;
    @(negedge clk);
    bus.W_in_valid = 1'b0; bus.W_flush = 1'b0;
    seen = bus.R_out_valid;
    repeat (3) begin
      @(negedge clk);
      if (bus.R_out_valid) seen = 1'b1;
    end
    check("flush_wins_accept", {seen, bus.R_in_ready}, {1'b0, 1'b1});

    // Asynchronous reset in the middle of a DIV clears everything before the next edge.
    @(negedge clk);
    bus.W_op_sel = 4'd13; bus.W_a = 32'd100; bus.W_b = 32'd7; bus.W_in_valid = 1'b1;
    @(posedge clk);
    #1 bus.W_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_mid_div", {bus.R_in_ready, bus.R_out_valid, bus.R_res_lo, bus.R_res_hi,
                                      bus.R_overflow, bus.R_div_zero}, {1'b1, 1'b0, 64'd0, 2'b00});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.R_out_valid) seen = 1'b1;
    end
    check("reset_no_partial", seen, 1'b0);
    do_op(4'd0, 32'd1, 32'd2, lo, hi, ov, dz, lat);
    check("post_reset_add", {lo, hi, ov, dz, 32'(lat)}, {32'd3, 32'd0, 2'b00, 32'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
